// File: rtl/node_port.sv
// One-entry blocking rendezvous channel between a writer node and a reader node.
// Values are saturated to +/-LIMIT on entry and handed over one at a time (IDLE -> FULL -> HOLD).
module node_port #(
    parameter int WIDTH = 11,
    parameter int LIMIT = 999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_done,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FULL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic signed [WIDTH-1:0] LIM_POS = WIDTH'(LIMIT);
    localparam logic signed [WIDTH-1:0] LIM_NEG = -LIM_POS;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_done_q, wr_done_d;

    function automatic logic [WIDTH-1:0] sat(input logic signed [WIDTH-1:0] x);
        if (x > LIM_POS) return LIM_POS;
        if (x < LIM_NEG) return LIM_NEG;
        return x;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        buf_d      = buf_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_done_d  = 1'b0;

        if (clk_en) begin
            unique case (state_q)
                IDLE: begin
                    if (wr_valid) begin
                        buf_d   = sat(wr_data);
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (rd_req) begin
                        rd_data_d  = buf_q;
                        rd_valid_d = 1'b1;
                        wr_done_d  = 1'b1;
                        state_d    = HOLD;
                    end
                end
                // One dead cycle lets the writer drop wr_valid after wr_done.
                HOLD:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign wr_done  = wr_done_q;
    assign rd_data  = rd_data_q;
    assign full     = (state_q == FULL);

endmodule

// File: doc/node_port.md
NODE_PORT -- requirements
Module: node_port

Interface
REQ-001 Parameter WIDTH, default 11, SHALL set the signed two's-complement data width.
REQ-002 Parameter LIMIT, default 999, SHALL set the saturation magnitude for stored values.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 clk_en  input  1  SHALL be the node step enable; state transitions SHALL occur only on edges where clk_en=1.
REQ-006 wr_valid  input  1  SHALL mean the writer node offers wr_data and is blocked awaiting completion.
REQ-007 wr_data  input  WIDTH  SHALL carry the signed value offered by the writer.
REQ-008 wr_done  output  1  SHALL be a one-cycle pulse meaning the offered value was consumed by the reader.
REQ-009 rd_req  input  1  SHALL mean the reader node is blocked requesting a value.
REQ-010 rd_valid  output  1  SHALL be a one-cycle pulse qualifying rd_data.
REQ-011 rd_data  output  WIDTH  SHALL carry the delivered signed value, held until the next delivery.
REQ-012 full  output  1  SHALL be 1 while a value is stored and not yet delivered.

Function
REQ-013 The block SHALL be a one-entry blocking rendezvous channel with states IDLE, FULL, HOLD.
REQ-014 IDLE, clk_en=1, wr_valid=1: SHALL latch sat(wr_data) into the buffer and go to FULL; full=1 from the next cycle (1-cycle latency).
REQ-015 sat(x): x>LIMIT -> LIMIT; x<-LIMIT -> -LIMIT; otherwise x; comparisons SHALL be signed.
REQ-016 IDLE, rd_req=1, wr_valid=0: no state change, no rd_valid; the reader stays blocked.
REQ-017 IDLE with wr_valid=1 and rd_req=1 together: SHALL accept the write only; delivery SHALL occur at the earliest one cycle later (no bypass).
REQ-018 FULL, clk_en=1, rd_req=1: SHALL load rd_data from the buffer, assert rd_valid and wr_done on the same edge, and go to HOLD.
REQ-019 FULL, rd_req=0: SHALL hold the buffer; wr_valid and wr_data changes SHALL be ignored (the buffer is not overwritten).
REQ-020 HOLD, clk_en=1: SHALL return to IDLE, ignoring wr_valid on that edge, so the writer has one cycle to drop wr_valid after wr_done.
REQ-021 rd_valid and wr_done SHALL deassert on the first clk edge after assertion, regardless of clk_en.
REQ-022 clk_en=0 in any state: SHALL freeze state, buffer, full and rd_data.
REQ-023 full SHALL be 1 exactly in state FULL; it SHALL be 0 in IDLE and HOLD.
REQ-024 End-to-end: write accepted at edge N, rd_req held high -> rd_valid and wr_done at edge N+1; the next write is accepted no earlier than edge N+3.

Reset
REQ-025 reset=0 SHALL immediately force state=IDLE, buffer=0, rd_data=0, rd_valid=0, wr_done=0 and full=0, independent of clk and clk_en.
REQ-026 Reset asserted mid-transfer (FULL or HOLD) SHALL discard the stored value; no rd_valid or wr_done SHALL follow.
REQ-027 Reset release SHALL take effect at the first rising edge with reset=1; the first write can be accepted on that edge.

Verification
REQ-028 Basic transfer: wr_valid=1, wr_data=+42 at edge 0; rd_req=1 from edge 1 -> full=1 after edge 0; rd_valid=1, rd_data=42, wr_done=1 after edge 1; full=0 after edge 1.
REQ-029 Saturation: write +1000, then -1024, then -999, each read out -> rd_data = +999, -999, -999.
REQ-030 Blocking reader: rd_req=1 for 5 cycles with no write -> no rd_valid; write -7 -> rd_valid one cycle later with rd_data=-7 (bit pattern 11'h7F9).
REQ-031 No overwrite: write 5, hold reader off 3 cycles while wr_data changes to 9 -> delivered value 5; wr_done pulses exactly once.
REQ-032 clk_en gating: clk_en=0 for 4 cycles while in FULL with rd_req=1 -> no rd_valid and full stays 1; clk_en=1 -> delivery on the next edge.
REQ-033 Async reset: assert reset=0 between edges while FULL -> full=0 and rd_data=0 before the next edge; after release, rd_req alone produces no rd_valid.
